ov7670_stream_emulator: RTL and testbench
=========================================

# ov7670_stream_emulator

Synthesizable OV7670 pixel-stream source that drives `pclk`/`href`/`vsync`/`data[7:0]` exactly as a camera does, in RGB565 with the high byte first. It sits on the camera-input side of the dice-race system as a drop-in replacement for a physical sensor (CAM1 or CAM2). It feeds the OV7670 capture path so that the frame buffer, color detection and the VGA chain can be exercised on the bench and on board without a camera. All logic runs on the system clock; `pclk` is a divided, registered output.

## Interface
- `IMG_WIDTH`, 160, active pixels per line (multiple of 8)
- `IMG_HEIGHT`, 120, active lines per frame
- `H_BLANK`, 16, pclk periods with href low after each line's active bytes
- `VSYNC_LINES`, 3, lines with vsync high
- `V_BACK`, 2, blank lines between vsync and the first active line
- `V_FRONT`, 2, blank lines after the last active line
- `CLK_DIV`, 2, clk cycles per pclk half-period (≥1)
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `enable` in 1: run frames continuously while high
- `pattern_sel` in 2: 0 solid, 1 color bars, 2 gradient, 3 checker
- `solid_rgb` in 16: RGB565 value used by pattern 0
- `pclk` out 1: emulated pixel clock
- `href` out 1: line-valid
- `vsync` out 1: frame sync, active high
- `data` out 8: pixel byte
- `frame_done` out 1: one-clk pulse at the end of each frame
- `frame_cnt` out 16: completed frames, wraps at 0xFFFF→0
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- Divider counts 0..CLK_DIV-1; at terminal count (tick) pclk toggles. A "fall event" is a tick with pclk=1. All stream state advances only on fall events, so data/href/vsync change just after pclk falls and are stable at the pclk rising edge.
- Line = 2·IMG_WIDTH + H_BLANK pclk periods. byte_cnt 0..2·IMG_WIDTH-1 is the active region; the rest is blank.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Line counter reloads per state.
  - IDLE→VSYNC on a fall event with enable=1; pattern_sel and solid_rgb are latched at this transition.
  - VSYNC (VSYNC_LINES lines) → VBACK (V_BACK lines) → ACTIVE (IMG_HEIGHT lines) → VFRONT (V_FRONT lines).
  - At the end of VFRONT: frame_done pulses, frame_cnt increments, then the FSM goes to VSYNC if enable=1, else IDLE.
- vsync=1 for the whole of VSYNC lines. href=1 only in ACTIVE lines during the active bytes.
- Pixel x = byte_cnt>>1, y = active line index. Even byte = pixel[15:8], odd byte = pixel[7:0]. data=0 whenever href=0.
- Patterns:
  - 0: solid_rgb.
  - 1: 8 equal bars, index x/(IMG_WIDTH/8): FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2: {x[4:0], y[5:0], 5'b0}.
  - 3: (x[3]^y[3]^frame_cnt[0]) ? FFFF : 0000.
- Deasserting enable mid-frame has no effect until the frame completes. Input changes mid-frame are ignored.

## Timing
- Reset values: pclk=0, href=0, vsync=0, data=0, frame_done=0, frame_cnt=0, busy=0, state IDLE, divider 0.
- After reset release with enable=1, the first fall event is at clk 2·CLK_DIV. vsync rises on that cycle.
- Defaults: line 336 pclk, frame 127 lines = 42 672 pclk = 170 688 clk.
- frame_done is coincident with the final fall event of VFRONT, and frame_cnt updates on the same edge. Back-to-back frames have no gap.
- Reset asserted mid-frame: all outputs return to reset values on the next clk edge. The partial frame is not counted.

## Configuration
- `OV7670_EMU_FRAME_TAG_EN` defined: pixel (0,0) of each frame carries frame_cnt (value before the increment for that frame) instead of the pattern, so the receiver can check frame ordering.
- Undefined: pixel (0,0) is the pattern value. No tag logic is built.

## Test plan
- Reset, then enable=0 for 1000 clk → pclk toggles every 2 clk; href=vsync=0, busy=0, frame_cnt=0.
- enable=1, pattern 1 → first active line bytes FF FF … (40 bytes) then FF E0 …; href high 320 pclk, low 16; vsync high exactly 3·336 pclk.
- Pattern 0, solid_rgb=0x1234 (tag undefined) → all 19 200 pixels read 12 34; frame_done pulses once per 170 688 clk; frame_cnt=1 after the first frame.
- Change pattern_sel 0→3 mid-ACTIVE → rest of the frame stays solid; next frame is checker with frame_cnt[0]=1 inverting the phase.
- Drop enable on line 60 → frame completes, frame_done pulses, FSM goes to IDLE, busy=0, no further vsync.
- With `OV7670_EMU_FRAME_TAG_EN`, third frame → first two active bytes 00 02. Reset at line 50 → outputs are 0 on the next clk and frame_cnt=0.

Source files
------------

// File: rtl/ov7670_stream_emulator.sv
// OV7670-style RGB565 pixel-stream source (pclk/href/vsync/data, high byte first).
// Define OV7670_EMU_FRAME_TAG_EN to replace pixel (0,0) of each frame with frame_cnt.
module ov7670_stream_emulator #(
    parameter int IMG_WIDTH   = 160,
    parameter int IMG_HEIGHT  = 120,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2,
    parameter int CLK_DIV     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        pclk,
    output logic        href,
    output logic        vsync,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LINE_LEN  = 2 * IMG_WIDTH + H_BLANK;
    localparam int ACT_BYTES = 2 * IMG_WIDTH;
    localparam int BAR_W     = IMG_WIDTH / 8;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic        pclk_q, pclk_d;
    logic [15:0] byte_q, byte_d;
    logic [15:0] line_q, line_d;
    logic [1:0]  pat_q, pat_d;
    logic [15:0] solid_q, solid_d;
    logic        href_q, href_d;
    logic        vsync_q, vsync_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        busy_q, busy_d;
    logic        tick_s, fall_s;
    logic [15:0] x_s, pix_s;
    logic [5:0]  y_s;

    function automatic logic [15:0] state_lines(input state_t s);
        case (s)
            VSYNC:   state_lines = 16'(VSYNC_LINES);
            VBACK:   state_lines = 16'(V_BACK);
            ACTIVE:  state_lines = 16'(IMG_HEIGHT);
            VFRONT:  state_lines = 16'(V_FRONT);
            default: state_lines = 16'd1;
        endcase
    endfunction

    // Bar index by threshold comparison avoids a divider for non-power-of-two widths.
    function automatic logic [2:0] bar_index(input logic [15:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= 16'(k * BAR_W)) idx = idx + 3'd1;
            else                     idx = idx;
        end
        return idx;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] i);
        case (i)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] pattern_pixel(input logic [1:0] sel, input logic [15:0] solid,
                                                  input logic [15:0] x, input logic [5:0] y,
                                                  input logic fc0);
        case (sel)
            2'd0:    pattern_pixel = solid;
            2'd1:    pattern_pixel = bar_color(bar_index(x));
            2'd2:    pattern_pixel = {x[4:0], y, 5'b00000};
            2'd3:    pattern_pixel = (x[3] ^ y[3] ^ fc0) ? 16'hFFFF : 16'h0000;
            default: pattern_pixel = solid;
        endcase
    endfunction

    // Divider, frame sequencing and output next-state; outputs derive from next stream state.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pclk_d  = pclk_q;
        byte_d  = byte_q;
        line_d  = line_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;

        tick_s = (div_q == DIV_LAST);
        fall_s = tick_s & pclk_q;
        if (tick_s) begin
            div_d  = '0;
            pclk_d = ~pclk_q;
        end else begin
            div_d  = div_q + DW'(1);
            pclk_d = pclk_q;
        end

        if (fall_s) begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = VSYNC;
                        byte_d  = 16'd0;
                        line_d  = 16'd0;
                        pat_d   = pattern_sel;
                        solid_d = solid_rgb;
                    end else begin
                        state_d = IDLE;
                    end
                end
                VSYNC, VBACK, ACTIVE, VFRONT: begin
                    if (byte_q == 16'(LINE_LEN - 1)) begin
                        byte_d = 16'd0;
                        if (line_q == state_lines(state_q) - 16'd1) begin
                            line_d = 16'd0;
                            case (state_q)
                                VSYNC:  state_d = VBACK;
                                VBACK:  state_d = ACTIVE;
                                ACTIVE: state_d = VFRONT;
                                VFRONT: begin
                                    done_d = 1'b1;
                                    fcnt_d = fcnt_q + 16'd1;
                                    if (enable) begin
                                        state_d = VSYNC;
                                        pat_d   = pattern_sel;
                                        solid_d = solid_rgb;
                                    end else begin
                                        state_d = IDLE;
                                    end
                                end
                                default: state_d = IDLE;
                            endcase
                        end else begin
                            line_d = line_q + 16'd1;
                        end
                    end else begin
                        byte_d = byte_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        x_s   = {1'b0, byte_d[15:1]};
        y_s   = line_d[5:0];
        pix_s = pattern_pixel(pat_d, solid_d, x_s, y_s, fcnt_q[0]);
`ifdef OV7670_EMU_FRAME_TAG_EN
        if ((x_s == 16'd0) && (line_d == 16'd0)) pix_s = fcnt_q;
        else                                     pix_s = pix_s;
`endif
        vsync_d = (state_d == VSYNC);
        href_d  = (state_d == ACTIVE) && (byte_d < 16'(ACT_BYTES));
        busy_d  = (state_d != IDLE);
        if (href_d) data_d = byte_d[0] ? pix_s[7:0] : pix_s[15:8];
        else        data_d = 8'h00;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            pclk_q  <= 1'b0;
            byte_q  <= 16'd0;
            line_q  <= 16'd0;
            pat_q   <= 2'd0;
            solid_q <= 16'd0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            fcnt_q  <= 16'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            href_q  <= href_d;
            vsync_q <= vsync_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= busy_d;
        end
    end

    assign pclk       = pclk_q;
    assign href       = href_q;
    assign vsync      = vsync_q;
    assign data       = data_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ov7670_stream_emulator.sv
// Directed bench for ov7670_stream_emulator using a reduced frame geometry.
module tb_ov7670_stream_emulator;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int HB = 4;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int CD = 2;
    localparam int LL = 2 * W + HB;
    localparam int FL = VS + VB + H + VF;
    localparam int FRAME_CLK = LL * FL * 2 * CD;
    localparam int ACT0 = (VS + VB) * LL;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        pclk, href, vsync, frame_done, busy;
    logic [7:0]  data;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int fd_count = 0;
    bit rec_en = 1'b0;
    logic pclk_prev = 1'b0;
    logic h_log[$];
    logic v_log[$];
    logic [7:0] d_log[$];
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    ov7670_stream_emulator #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .VSYNC_LINES(VS),
        .V_BACK(VB), .V_FRONT(VF), .CLK_DIV(CD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .pclk(pclk), .href(href), .vsync(vsync),
        .data(data), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Log href/vsync/data at every pclk rising edge while a frame is in progress.
    always @(negedge clk) begin
        pclk_prev <= pclk;
        if (frame_done === 1'b1) fd_count <= fd_count + 1;
        if (rec_en && busy && pclk && !pclk_prev) begin
            h_log.push_back(href);
            v_log.push_back(vsync);
            d_log.push_back(data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_frame(input int act_at, input logic [1:0] sel, input logic [15:0] solid,
                             input logic en, output int ncyc, output int vs_at);
        bit seen;
        seen = 1'b0;
        ncyc = 0;
        vs_at = -1;
        h_log.delete();
        v_log.delete();
        d_log.delete();
        rec_en = 1'b1;
        while (!seen && ncyc < 3000) begin
            @(negedge clk);
            ncyc++;
            if (ncyc == act_at) begin
                pattern_sel = sel;
                solid_rgb = solid;
                enable = en;
            end
            if (vs_at < 0 && vsync === 1'b1) vs_at = ncyc;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        rec_en = 1'b0;
        check_eq("frame_done_seen", {31'd0, seen}, 32'd1);
        check_eq("frame_len", h_log.size(), LL * FL);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pclk"}, pclk, 1'b0);
        check_eq({tag, "_href"}, href, 1'b0);
        check_eq({tag, "_vsync"}, vsync, 1'b0);
        check_eq({tag, "_data"}, data, 8'h00);
        check_eq({tag, "_frame_done"}, frame_done, 1'b0);
        check_eq({tag, "_frame_cnt"}, frame_cnt, 16'h0000);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int n, vs, cnt, bad, toggles, idx;
        logic prev;
        logic [15:0] exp00;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Idle: pclk runs, nothing else moves.
        reset = 1'b0;
        toggles = 0;
        bad = 0;
        prev = pclk;
        repeat (40) begin
            @(negedge clk);
            if (pclk !== prev) toggles++;
            prev = pclk;
            if (href !== 1'b0 || vsync !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_eq("idle_pclk_toggles", toggles, 20);
        check_eq("idle_quiet", bad, 0);
        check_eq("idle_frame_cnt", frame_cnt, 16'd0);

        // Frame A: colour bars; mid-ACTIVE switch to solid must not take effect.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'd1;
        run_frame(600, 2'd0, 16'h1234, 1'b1, n, vs);
        check_eq("first_vsync_clk", vs, 2 * CD);
        check_eq("first_frame_clk", n, 2 * CD + FRAME_CLK);
        check_eq("frame_cnt_1", frame_cnt, 16'd1);
        cnt = 0;
        foreach (v_log[i]) if (v_log[i]) cnt++;
        check_eq("vsync_pclks", cnt, VS * LL);
        check_eq("vsync_last_hi", v_log[VS * LL - 1], 1'b1);
        check_eq("vsync_first_lo", v_log[VS * LL], 1'b0);
        cnt = 0;
        bad = 0;
        foreach (h_log[i]) begin
            if (h_log[i]) cnt++;
            else if (d_log[i] !== 8'h00) bad++;
        end
        check_eq("href_total", cnt, H * 2 * W);
        check_eq("data_zero_blank", bad, 0);
        cnt = 0;
        while (cnt < LL && h_log[ACT0 + cnt]) cnt++;
        check_eq("href_high_run", cnt, 2 * W);
        bad = 0;
        while (bad < LL && !h_log[ACT0 + cnt + bad]) bad++;
        check_eq("href_low_run", bad, HB);
        for (int b = 0; b < 8; b++) begin
            idx = ACT0 + LL + 4 * b;
            check_eq("bar_hi", d_log[idx], bars[b][15:8]);
            check_eq("bar_lo", d_log[idx + 1], bars[b][7:0]);
            idx = ACT0 + 3 * LL + 4 * b + 2;
            check_eq("bar_last_line", {d_log[idx], d_log[idx + 1]}, bars[b]);
        end

        // Frame B: solid 0x1234; a switch to checker arrives mid-ACTIVE.
        run_frame(600, 2'd3, 16'h1234, 1'b1, n, vs);
        check_eq("frame_period_clk", n, FRAME_CLK);
        check_eq("frame_cnt_2", frame_cnt, 16'd2);
        bad = 0;
        for (int l = 0; l < H; l++) begin
            for (int b = 0; b < 2 * W; b++) begin
`ifdef OV7670_EMU_FRAME_TAG_EN
                if (l == 0 && b < 2) continue;
`endif
                if (d_log[ACT0 + l * LL + b] !== ((b % 2 == 0) ? 8'h12 : 8'h34)) bad++;
            end
        end
        check_eq("solid_bytes_bad", bad, 0);

        // Frame C: checker, frame_cnt=2 during the frame.
        run_frame(0, 2'd3, 16'h1234, 1'b1, n, vs);
`ifdef OV7670_EMU_FRAME_TAG_EN
        exp00 = 16'h0002;
`else
        exp00 = 16'h0000;
`endif
        check_eq("c_pixel00", {d_log[ACT0], d_log[ACT0 + 1]}, exp00);
        check_eq("c_checker_x0", d_log[ACT0 + LL], 8'h00);
        check_eq("c_checker_x8", d_log[ACT0 + LL + 16], 8'hFF);
        check_eq("frame_cnt_3", frame_cnt, 16'd3);

        // Frame D: checker phase inverted; enable drops mid-frame.
        run_frame(600, 2'd3, 16'h1234, 1'b0, n, vs);
`ifdef OV7670_EMU_FRAME_TAG_EN
        exp00 = 16'h0003;
`else
        exp00 = 16'hFFFF;
`endif
        check_eq("d_pixel00", {d_log[ACT0], d_log[ACT0 + 1]}, exp00);
        check_eq("d_checker_x0", d_log[ACT0 + LL], 8'hFF);
        check_eq("d_checker_x8", d_log[ACT0 + LL + 16], 8'h00);
        check_eq("frame_cnt_4", frame_cnt, 16'd4);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (vsync !== 1'b0 || busy !== 1'b0 || href !== 1'b0) bad++;
        end
        check_eq("idle_after_disable", bad, 0);
        check_eq("frame_done_pulses", fd_count, 4);

        // Gradient frame after a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'd2;
        run_frame(0, 2'd2, 16'h0000, 1'b1, n, vs);
        idx = ACT0 + 2 * LL + 10;
        check_eq("grad_x5_y2", {d_log[idx], d_log[idx + 1]}, 16'h2840);
        idx = ACT0 + 3 * LL + 30;
        check_eq("grad_x15_y3", {d_log[idx], d_log[idx + 1]}, 16'h7860);
        check_eq("grad_frame_cnt", frame_cnt, 16'd1);

        // Reset in the middle of an active line.
        cnt = 0;
        while (href !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("href_reached", {31'd0, href}, 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
